// File: rtl/hwpf_nl_gen.sv
// Next-line prefetch generator: on a demand miss, request line+1 unless it crosses
// a page, was recently issued (FIFO history filter), or the downstream queue is full.
module hwpf_nl_gen #(
    parameter int LANE_SIZE  = 64,
    parameter int ADDR_W     = 40,
    parameter int PAGE_SIZE  = 4096,
    parameter int HIST_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              flush_i,
    input  logic              lock_i,
    input  logic              queue_full_i,
    input  logic              miss_valid_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              pf_valid_o,
    output logic [ADDR_W-1:0] pf_addr_o,
    output logic [6:0]        pf_tid_o,
    output logic [CNT_W-1:0]  issued_cnt_o,
    output logic [CNT_W-1:0]  dropped_cnt_o
);
    localparam int OFF_W = $clog2(LANE_SIZE);
    localparam int LN_W  = ADDR_W - OFF_W;
    localparam int PG_W  = $clog2(PAGE_SIZE / LANE_SIZE);
    localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    // Low line-index bits within a page; all-zero after +1 means the next line is in a new page.
    localparam logic [LN_W-1:0] PG_MASK = LN_W'((64'd1 << PG_W) - 64'd1);
    localparam logic [LN_W-1:0] LN_ONE  = LN_W'(1);

    logic              pf_vld_q, pf_vld_d;
    logic [LN_W-1:0]   pf_line_q, pf_line_d;
    logic [6:0]        pf_tid_q, pf_tid_d;
    logic [6:0]        tid_q, tid_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  dropped_q, dropped_d;
    logic [LN_W-1:0]   hist_q [HIST_DEPTH];
    logic [LN_W-1:0]   hist_d [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hist_vld_q, hist_vld_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;

    logic              trig;
    logic [LN_W-1:0]   nxt;
    logic              page_cross;
    logic              hist_hit;
    logic              unused_offset;

    assign trig          = miss_valid_i & enable_i & ~lock_i & ~flush_i;
    assign nxt           = miss_addr_i[ADDR_W-1:OFF_W] + LN_ONE;
    assign page_cross    = (nxt & PG_MASK) == '0;
    assign unused_offset = ^(miss_addr_i & ADDR_W'(LANE_SIZE - 1));

    always_comb begin
        hist_hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_vld_q[i] && (hist_q[i] == nxt)) hist_hit = 1'b1;
        end
    end

    always_comb begin
        pf_vld_d   = 1'b0;
        pf_line_d  = pf_line_q;
        pf_tid_d   = pf_tid_q;
        tid_d      = tid_q;
        issued_d   = issued_q;
        dropped_d  = dropped_q;
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        wptr_d     = wptr_q;
        if (flush_i) begin
            hist_vld_d = '0;
        end else if (trig) begin
            if (page_cross || hist_hit || queue_full_i) begin
                if (~&dropped_q) dropped_d = dropped_q + 1'b1;
            end else begin
                pf_vld_d           = 1'b1;
                pf_line_d          = nxt;
                pf_tid_d           = tid_q;
                tid_d              = tid_q + 7'd1;
                if (~&issued_q) issued_d = issued_q + 1'b1;
                hist_d[wptr_q]     = nxt;
                hist_vld_d[wptr_q] = 1'b1;
                wptr_d = (wptr_q == PTR_W'(HIST_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pf_vld_q   <= 1'b0;
            pf_line_q  <= '0;
            pf_tid_q   <= '0;
            tid_q      <= '0;
            issued_q   <= '0;
            dropped_q  <= '0;
            hist_vld_q <= '0;
            wptr_q     <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            pf_vld_q   <= pf_vld_d;
            pf_line_q  <= pf_line_d;
            pf_tid_q   <= pf_tid_d;
            tid_q      <= tid_d;
            issued_q   <= issued_d;
            dropped_q  <= dropped_d;
            hist_vld_q <= hist_vld_d;
            wptr_q     <= wptr_d;
            hist_q     <= hist_d;
        end
    end

    assign pf_valid_o    = pf_vld_q;
    assign pf_addr_o     = ADDR_W'(pf_line_q) << OFF_W;
    assign pf_tid_o      = pf_tid_q;
    assign issued_cnt_o  = issued_q;
    assign dropped_cnt_o = dropped_q;
endmodule

// File: tb/tb_hwpf_nl_gen.sv
// Directed bench for hwpf_nl_gen with hand-computed expectations.
module tb_hwpf_nl_gen;
    localparam int ADDR_W = 40;
    localparam int CNT_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              enable_i = 1'b1;
    logic              flush_i = 1'b0;
    logic              lock_i = 1'b0;
    logic              queue_full_i = 1'b0;
    logic              miss_valid_i = 1'b0;
    logic [ADDR_W-1:0] miss_addr_i = '0;
    logic              pf_valid_o;
    logic [ADDR_W-1:0] pf_addr_o;
    logic [6:0]        pf_tid_o;
    logic [CNT_W-1:0]  issued_cnt_o;
    logic [CNT_W-1:0]  dropped_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    hwpf_nl_gen #(.LANE_SIZE(64), .ADDR_W(ADDR_W), .PAGE_SIZE(4096),
                  .HIST_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
        .lock_i(lock_i), .queue_full_i(queue_full_i), .miss_valid_i(miss_valid_i),
        .miss_addr_i(miss_addr_i), .pf_valid_o(pf_valid_o), .pf_addr_o(pf_addr_o),
        .pf_tid_o(pf_tid_o), .issued_cnt_o(issued_cnt_o), .dropped_cnt_o(dropped_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic miss(input logic [ADDR_W-1:0] a);
        miss_valid_i = 1'b1;
        miss_addr_i  = a;
        tick();
        miss_valid_i = 1'b0;
    endtask

    task automatic chk_pulse(input string tag, input logic [ADDR_W-1:0] a, input int tid);
        chk({tag, ".vld"}, 64'(pf_valid_o), 64'd1);
        chk({tag, ".addr"}, 64'(pf_addr_o), 64'(a));
        chk({tag, ".tid"}, 64'(pf_tid_o), 64'(tid));
    endtask

    logic [ADDR_W-1:0] t4_miss [6];

    initial begin
        t4_miss = '{40'h3000_0000, 40'h3000_0040, 40'h3000_0080,
                    40'h3000_00C0, 40'h3000_0100, 40'h3000_0000};
        #2;
        chk("rst.vld", 64'(pf_valid_o), 64'd0);
        chk("rst.addr", 64'(pf_addr_o), 64'd0);
        chk("rst.tid", 64'(pf_tid_o), 64'd0);
        chk("rst.iss", 64'(issued_cnt_o), 64'd0);
        chk("rst.drp", 64'(dropped_cnt_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // 1: basic next-line
        miss(40'h1000_0040);
        chk_pulse("t1", 40'h1000_0080, 0);
        chk("t1.iss", 64'(issued_cnt_o), 64'd1);
        tick();
        chk("t1.one_cycle", 64'(pf_valid_o), 64'd0);

        // 2: same miss on consecutive cycles issues once
        miss_valid_i = 1'b1;
        miss_addr_i  = 40'h1100_0040;
        tick();
        chk_pulse("t2a", 40'h1100_0080, 1);
        tick();
        miss_valid_i = 1'b0;
        chk("t2b.vld", 64'(pf_valid_o), 64'd0);
        chk("t2b.drp", 64'(dropped_cnt_o), 64'd1);
        chk("t2b.hold", 64'(pf_addr_o), 64'h1100_0080);

        // 3: page cross
        miss(40'h1000_0FC0);
        chk("t3.vld", 64'(pf_valid_o), 64'd0);
        chk("t3.drp", 64'(dropped_cnt_o), 64'd2);
        chk("t3.tid", 64'(pf_tid_o), 64'd1);

        // 4: history eviction after five inserts into four entries
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            miss(t4_miss[i]);
            chk_pulse($sformatf("t4.%0d", i), t4_miss[i] + 40'h40, 2 + i);
        end
        chk("t4.iss", 64'(issued_cnt_o), 64'd8);
        miss(40'h3000_0100);
        chk("t4.hit.vld", 64'(pf_valid_o), 64'd0);
        chk("t4.hit.drp", 64'(dropped_cnt_o), 64'd3);

        // 5: flush discards the same-cycle trigger and clears history
        flush_i = 1'b1;
        miss(40'h2000_0000);
        flush_i = 1'b0;
        chk("t5.vld", 64'(pf_valid_o), 64'd0);
        chk("t5.drp", 64'(dropped_cnt_o), 64'd3);
        chk("t5.iss", 64'(issued_cnt_o), 64'd8);
        miss(40'h3000_0100);
        chk_pulse("t5b", 40'h3000_0140, 8);
        chk("t5b.iss", 64'(issued_cnt_o), 64'd9);

        // lock and disable ignore triggers; history survives disable
        lock_i = 1'b1;
        miss(40'h4000_0000);
        lock_i = 1'b0;
        chk("lock.vld", 64'(pf_valid_o), 64'd0);
        chk("lock.drp", 64'(dropped_cnt_o), 64'd3);
        enable_i = 1'b0;
        miss(40'h4000_0000);
        enable_i = 1'b1;
        chk("dis.vld", 64'(pf_valid_o), 64'd0);
        chk("dis.iss", 64'(issued_cnt_o), 64'd9);
        miss(40'h3000_0100);
        chk("reen.vld", 64'(pf_valid_o), 64'd0);
        chk("reen.drp", 64'(dropped_cnt_o), 64'd4);

        // reset mid-operation loses the pending pulse
        miss_valid_i = 1'b1;
        miss_addr_i  = 40'h6000_0000;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mrst.iss", 64'(issued_cnt_o), 64'd0);
        chk("mrst.drp", 64'(dropped_cnt_o), 64'd0);
        tick();
        miss_valid_i = 1'b0;
        chk("mrst.vld", 64'(pf_valid_o), 64'd0);
        chk("mrst.tid", 64'(pf_tid_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // 6: tid wrap over 129 accepted triggers
        for (int i = 0; i < 129; i++) begin
            miss(40'h5000_0000 + (40'(i) << 12));
            chk_pulse($sformatf("t6.%0d", i), 40'h5000_0040 + (40'(i) << 12), i % 128);
        end
        chk("t6.iss", 64'(issued_cnt_o), 64'd129);
        queue_full_i = 1'b1;
        miss(40'h7000_0000);
        queue_full_i = 1'b0;
        chk("full.vld", 64'(pf_valid_o), 64'd0);
        chk("full.drp", 64'(dropped_cnt_o), 64'd1);
        chk("full.iss", 64'(issued_cnt_o), 64'd129);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
